// File: rtl/cache_nway_pkg.sv
// Shared types and constants for the N-way write-back cache.
package cache_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned OFF_W     = 5;

  // Ceiling log2, used to size way/index/tag fields from the parameters.
  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_nway_plru.sv
// Tree pseudo-LRU: next-state update for an accessed way and victim lookup.
// Node n has children 2n+1 (lower half) and 2n+2 (upper half); a node bit
// of 0 means the victim lies in the lower half.
module plru_tree
  import cache_types::*;
#(
  parameter int unsigned WAYS = 4,
  localparam int unsigned WW  = log2_ceil(WAYS)
) (
  input  logic [WAYS-2:0] cur_bits,
  input  logic [WW-1:0]   way,
  output logic [WAYS-2:0] next_bits,
  output logic [WW-1:0]   victim
);

  // Point every node on the accessed way's path away from that way.
  always_comb begin
    logic [WW-1:0] node;
    next_bits = cur_bits;
    node      = '0;
    for (int unsigned l = 0; l < WW; l++) begin
      next_bits[node] = ~way[WW-1-l];
      node = (node << 1) + WW'(1) + WW'(way[WW-1-l]);
    end
  end

  // Follow the node bits from the root to the victim leaf.
  always_comb begin
    logic [WW-1:0] vnode;
    victim = '0;
    vnode  = '0;
    for (int unsigned l = 0; l < WW; l++) begin
      victim[WW-1-l] = cur_bits[vnode];
      vnode = (vnode << 1) + WW'(1) + WW'(cur_bits[vnode]);
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache between a 32-bit
// CPU port (ufp) and a 256-bit line memory port (dfp).
module cache_nway
  import cache_types::*;
#(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ufp_addr,
  input  logic [3:0]           ufp_rmask,
  input  logic [3:0]           ufp_wmask,
  input  logic [31:0]          ufp_wdata,
  output logic [31:0]          ufp_rdata,
  output logic                 ufp_resp,
  output logic [31:0]          dfp_addr,
  output logic                 dfp_read,
  output logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  output logic [LINE_BITS-1:0] dfp_wdata,
  input  logic                 dfp_resp
);

  localparam int unsigned WW    = log2_ceil(WAYS);
  localparam int unsigned IDX_W = log2_ceil(SETS);
  localparam int unsigned TAG_W = 32 - OFF_W - IDX_W;

  state_t state;

  // Latched request; byte offset bits within the word are never needed.
  logic [31:2] req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic [WW-1:0] vic_q;
  logic [1:0]  addr_unused;

  // Storage arrays indexed by set.
  logic [TAG_W-1:0]     tag_arr  [WAYS][SETS];
  logic [LINE_BITS-1:0] data_arr [WAYS][SETS];
  logic [WAYS-1:0]      valid_arr [SETS];
  logic [WAYS-1:0]      dirty_arr [SETS];
  logic [WAYS-2:0]      plru_arr  [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word_sel;

  logic [WAYS-1:0]      hit_vec;
  logic                 hit;
  logic [WW-1:0]        hit_way;
  logic [LINE_BITS-1:0] hit_line;
  logic [LINE_BITS-1:0] merged_line;
  logic [31:0]          hit_word;
  logic                 req_write;

  logic [WAYS-2:0]      plru_next;
  logic [WW-1:0]        plru_victim;
  logic [WW-1:0]        vic_sel;
  logic                 vic_dirty;
  logic [TAG_W-1:0]     vic_tag;
  logic [LINE_BITS-1:0] vic_line;

  assign addr_unused = ufp_addr[1:0];
  assign idx         = req_addr[OFF_W +: IDX_W];
  assign tag         = req_addr[31 -: TAG_W];
  assign word_sel    = req_addr[4:2];
  assign req_write   = |req_wmask;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .cur_bits  (plru_arr[idx]),
    .way       (hit_way),
    .next_bits (plru_next),
    .victim    (plru_victim)
  );

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_arr[idx][w] && (tag_arr[w][idx] == tag);
      if (hit_vec[w]) hit_way = WW'(w);
    end
    hit = |hit_vec;
  end

  // Hit word extraction and byte-masked merge of the write data.
  always_comb begin
    hit_line    = data_arr[hit_way][idx];
    hit_word    = hit_line[{word_sel, 5'b00000} +: 32];
    merged_line = hit_line;
    for (int unsigned b = 0; b < 4; b++) begin
      if (req_wmask[b]) merged_line[{word_sel, 2'(b), 3'b000} +: 8] = req_wdata[8*b +: 8];
    end
  end

  // Victim choice: lowest invalid way wins over the PLRU pick.
  always_comb begin
    vic_sel = plru_victim;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_arr[idx][w]) vic_sel = WW'(w);
    end
    vic_dirty = valid_arr[idx][vic_sel] && dirty_arr[idx][vic_sel];
    vic_tag   = tag_arr[vic_sel][idx];
    vic_line  = data_arr[vic_sel][idx];
  end

  // Response and dfp strobes decode directly from state so reset drops them at once.
  always_comb begin
    ufp_resp  = (state == COMPARE) && hit;
    ufp_rdata = ufp_resp ? hit_word : '0;
    dfp_read  = (state == ALLOCATE);
    dfp_write = (state == WRITEBACK);
  end

  // Controller FSM with registered dfp address/data and valid/dirty/PLRU state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_wmask <= '0;
      req_wdata <= '0;
      vic_q     <= '0;
      dfp_addr  <= '0;
      dfp_wdata <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if ((|ufp_rmask) || (|ufp_wmask)) begin
            req_addr  <= ufp_addr[31:2];
            req_wmask <= ufp_wmask;
            req_wdata <= ufp_wdata;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            plru_arr[idx] <= plru_next;
            if (req_write) dirty_arr[idx][hit_way] <= 1'b1;
            state <= IDLE;
          end else begin
            vic_q <= vic_sel;
            if (vic_dirty) begin
              dfp_addr  <= {vic_tag, idx, {OFF_W{1'b0}}};
              dfp_wdata <= vic_line;
              state     <= WRITEBACK;
            end else begin
              dfp_addr <= {tag, idx, {OFF_W{1'b0}}};
              state    <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (dfp_resp) begin
            dirty_arr[idx][vic_q] <= 1'b0;
            dfp_wdata <= '0;
            dfp_addr  <= {tag, idx, {OFF_W{1'b0}}};
            state     <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (dfp_resp) begin
            valid_arr[idx][vic_q] <= 1'b1;
            dirty_arr[idx][vic_q] <= 1'b0;
            dfp_addr <= '0;
            state    <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data and tags: write hits merge bytes, fills replace the victim line.
  always_ff @(posedge clk) begin
    if (state == COMPARE && hit && req_write) begin
      data_arr[hit_way][idx] <= merged_line;
    end
    if (state == ALLOCATE && dfp_resp) begin
      data_arr[vic_q][idx] <= dfp_rdata;
      tag_arr[vic_q][idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// Scoreboard bench for cache_nway: a flat line-level reference memory gives
// the expected read word for every request; a dfp responder with programmable
// latency models the backing memory and checks handshake stability.
module tb_cache_nway #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 16
);

  localparam int unsigned STRIDE = SETS * 32;

  logic         clk;
  logic         rst_n;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [3:0]   ufp_wmask;
  logic [31:0]  ufp_wdata;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_rdata;
  logic [255:0] dfp_wdata;
  logic         dfp_resp;

  cache_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ufp_addr  (ufp_addr),
    .ufp_rmask (ufp_rmask),
    .ufp_wmask (ufp_wmask),
    .ufp_wdata (ufp_wdata),
    .ufp_rdata (ufp_rdata),
    .ufp_resp  (ufp_resp),
    .dfp_addr  (dfp_addr),
    .dfp_read  (dfp_read),
    .dfp_write (dfp_write),
    .dfp_rdata (dfp_rdata),
    .dfp_wdata (dfp_wdata),
    .dfp_resp  (dfp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Backing memory (updated only by writebacks) and the coherent CPU view.
  logic [255:0] mem   [logic [31:0]];
  logic [255:0] model [logic [31:0]];
  bit           written [logic [31:0]];
  logic [31:0]  exp_q [$];

  int unsigned dly = 0;
  int          fill_cnt = 0;
  int          wb_cnt = 0;
  logic [31:0] last_fill = '0;
  logic [31:0] last_wb = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [255:0] pattern(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ (32'h5A5A_0000 + 32'(w));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    return mem.exists(la) ? mem[la] : pattern(la);
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] la);
    return model.exists(la) ? model[la] : pattern(la);
  endfunction

  // dfp responder: answers after dly cycles, checks held request and writeback contents.
  initial begin
    bit          busy;
    int          cnt;
    logic [31:0] c_addr;
    logic        c_rd, c_wr;
    logic [255:0] c_wd;
    busy = 0; cnt = 0; c_addr = '0; c_rd = 0; c_wr = 0; c_wd = '0;
    dfp_resp = 1'b0;
    dfp_rdata = '0;
    forever begin
      @(negedge clk);
      if (dfp_resp) begin
        dfp_resp  = 1'b0;
        dfp_rdata = '0;
      end
      if (!rst_n) begin
        busy = 0;
      end else begin
        if (dfp_read && dfp_write) chk("dfp_exclusive", 1, 0);
        if (!dfp_write) chk("dfp_wdata_idle", dfp_wdata, 0);
        if (!busy) begin
          if (dfp_read || dfp_write) begin
            busy = 1; cnt = 0;
            c_addr = dfp_addr; c_rd = dfp_read; c_wr = dfp_write; c_wd = dfp_wdata;
            chk("dfp_addr_align", c_addr[4:0], 0);
          end
        end else begin
          cnt++;
          chk("dfp_addr_stable", dfp_addr, c_addr);
          chk("dfp_read_stable", dfp_read, c_rd);
          chk("dfp_write_stable", dfp_write, c_wr);
          chk("dfp_wdata_stable", dfp_wdata, c_wd);
        end
        if (busy && cnt >= int'(dly)) begin
          if (c_wr) begin
            chk("wb_dirty_line", written.exists(c_addr), 1);
            chk("wb_data", c_wd, model_line(c_addr));
            mem[c_addr] = c_wd;
            written.delete(c_addr);
            wb_cnt++;
            last_wb = c_addr;
          end else begin
            dfp_rdata = mem_line(c_addr);
            written.delete(c_addr);
            fill_cnt++;
            last_fill = c_addr;
          end
          dfp_resp = 1'b1;
          busy = 0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ufp_resp.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (ufp_resp) begin
          chk("resp_back_to_back", prev, 0);
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp: got rdata %0h expected no response", ufp_rdata);
          end else begin
            chk("ufp_rdata", ufp_rdata, exp_q.pop_front());
          end
        end else begin
          chk("ufp_rdata_idle", ufp_rdata, 0);
        end
        prev = ufp_resp;
      end
    end
  end

  // Issue one request from a negedge; returns latency in cycles and fills caused.
  task automatic access(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, output int lat, output int fills);
    logic [31:0]  la;
    logic [255:0] l;
    int           w;
    int           f0;
    la = {addr[31:5], 5'b0};
    l  = model_line(la);
    w  = int'(addr[4:2]);
    exp_q.push_back(l[w*32 +: 32]);
    if (wm != 4'h0) begin
      for (int b = 0; b < 4; b++) if (wm[b]) l[w*32 + b*8 +: 8] = wd[b*8 +: 8];
      model[la] = l;
    end
    f0 = fill_cnt;
    ufp_addr = addr; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        ufp_rmask = '0; ufp_wmask = '0;
        ufp_addr = $urandom; ufp_wdata = $urandom;
      end
      if (ufp_resp) break;
      if (lat > 200) begin
        chk("resp_timeout", 0, 1);
        exp_q.delete();
        break;
      end
    end
    if (wm != 4'h0) written[la] = 1;
    fills = fill_cnt - f0;
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, f, wb0, cnt;
    int           ds [3];
    int           sets [3];
    logic [31:0]  a, base;
    logic [3:0]   wm, rm;
    logic [255:0] l;
    ds = '{0, 1, 10};
    sets = '{0, 1, 3};

    l = pattern(32'h40);
    l[31:0]  = 32'hDEAD_BEEF;
    l[63:32] = 32'h1122_3344;
    mem[32'h40]   = l;
    model[32'h40] = l;

    rst_n = 1'b0; ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ufp_resp", ufp_resp, 0);
    chk("rst_ufp_rdata", ufp_rdata, 0);
    chk("rst_dfp_read", dfp_read, 0);
    chk("rst_dfp_write", dfp_write, 0);
    chk("rst_dfp_addr", dfp_addr, 0);
    chk("rst_dfp_wdata", dfp_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read, hit re-read, byte write, read-back of merged word.
    access(32'h40, 4'hF, 4'h0, 32'h0, lat, f);
    chk("cold_fill_count", f, 1);
    chk("cold_fill_addr", last_fill, 32'h40);
    chk("cold_miss_latency", lat, 3);
    access(32'h40, 4'hF, 4'h0, 32'h0, lat, f);
    chk("hit_latency", lat, 1);
    chk("hit_no_fill", f, 0);
    access(32'h44, 4'h0, 4'b0011, 32'h0000_ABCD, lat, f);
    chk("write_hit_latency", lat, 1);
    access(32'h44, 4'hF, 4'h0, 32'h0, lat, f);
    chk("readback_no_fill", f, 0);

    // Fill every way of one set, then evict the least recently used dirty line.
    wb0 = wb_cnt;
    access(32'h40, 4'h0, 4'hF, $urandom, lat, f);
    for (int k = 1; k < int'(WAYS); k++) access(32'(k) * STRIDE + 32'h40, 4'hF, 4'h0, 32'h0, lat, f);
    access(WAYS * STRIDE + 32'h40, 4'hF, 4'h0, 32'h0, lat, f);
    chk("evict_wb_count", wb_cnt - wb0, 1);
    chk("evict_wb_addr", last_wb, 32'h40);
    chk("evict_fill_addr", last_fill, WAYS * STRIDE + 32'h40);
    chk("dirty_miss_latency", lat, 4);
    access(STRIDE + 32'h40, 4'hF, 4'h0, 32'h0, lat, f);
    chk("evict_rehit_latency", lat, 1);

    // Clean and dirty misses under several memory latencies.
    for (int i = 0; i < 3; i++) begin
      dly  = ds[i];
      base = 32'(sets[i]) * 32;
      for (int k = 0; k < int'(WAYS); k++) begin
        wm = 4'($urandom_range(1, 15));
        access(base + 32'(k) * STRIDE + 32'(4 * (k % 8)), 4'h0, wm, $urandom, lat, f);
        chk("clean_miss_latency", lat, 3 + ds[i]);
      end
      access(base + WAYS * STRIDE, 4'hF, 4'h0, 32'h0, lat, f);
      chk("dirty_miss_latency_dly", lat, 4 + 2 * ds[i]);
      access(base + WAYS * STRIDE, 4'hF, 4'h0, 32'h0, lat, f);
      chk("hit_latency_dly", lat, 1);
    end

    // Reset asserted while a writeback is pending.
    dly = 10;
    ufp_addr = 32'(1) * 32 + (WAYS + 1) * STRIDE; ufp_rmask = 4'hF; ufp_wmask = '0;
    cnt = 0;
    while (1) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) ufp_rmask = '0;
      if (dfp_write) break;
      if (cnt > 100) begin
        chk("wb_start_timeout", 0, 1);
        break;
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dfp_write", dfp_write, 0);
    chk("rst_mid_dfp_read", dfp_read, 0);
    chk("rst_mid_ufp_resp", ufp_resp, 0);
    exp_q.delete();
    written.delete();
    model.delete();
    foreach (mem[k]) model[k] = mem[k];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dly = 0;
    @(negedge clk);
    access(32'h40, 4'hF, 4'h0, 32'h0, lat, f);
    chk("post_rst_fill_count", f, 1);
    chk("post_rst_fill_addr", last_fill, 32'h40);
    chk("post_rst_miss_latency", lat, 3);

    // Random traffic over a small address footprint.
    for (int n = 0; n < 400; n++) begin
      dly = $urandom_range(0, 3);
      a = 32'($urandom_range(0, 2 * WAYS)) * STRIDE + 32'($urandom_range(0, SETS - 1)) * 32
          + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 1) == 1) begin
        wm = 4'($urandom_range(1, 15));
        rm = 4'($urandom_range(0, 15));
      end else begin
        wm = 4'h0;
        rm = 4'($urandom_range(1, 15));
      end
      access(a, rm, wm, $urandom, lat, f);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cache_nway.md
# cache_nway

Parametrised N-way set-associative, write-back, write-allocate cache sitting between the CPU memory port (ufp) and the 256-bit line memory (dfp). It generalises the fixed 4-way read-only cache to configurable ways and sets. It adds:
- byte-masked writes
- per-line dirty tracking
- victim writeback over dfp
- tree-PLRU replacement for any power-of-two way count

## Interface
- WAYS, 4, associativity; power of two, 2..8
- SETS, 16, sets per way; power of two, 4..256
- (derived) IDX_W = log2(SETS); TAG_W = 32-5-IDX_W; address = {tag, index, offset[4:0]}
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ufp_addr  in  32  byte address; bits [4:2] select the word within the line
- ufp_rmask  in  4  read byte enables; nonzero = read request
- ufp_wmask  in  4  write byte enables; nonzero = write request (wins over rmask)
- ufp_wdata  in  32  write data, byte-lane aligned
- ufp_rdata  out  32  read word; valid only while ufp_resp=1, else 0
- ufp_resp  out  1  one-cycle completion pulse
- dfp_addr  out  32  line-aligned address; [4:0]=0
- dfp_read  out  1  line fill request, level
- dfp_write  out  1  line writeback request, level
- dfp_rdata  in  256  fill data
- dfp_wdata  out  256  writeback data; 0 when dfp_write=0
- dfp_resp  in  1  one-cycle completion of the current dfp_read/dfp_write

## Operation
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: if (rmask|wmask)!=0, latch addr/masks/wdata and go to COMPARE. ufp inputs are don't-care until ufp_resp.
- COMPARE, hit (valid && tag match in exactly one way):
  - ufp_resp=1; ufp_rdata = the stored word before any merge.
  - For a write, merge bytes per wmask and set dirty.
  - Update PLRU for the hit way; go to IDLE.
- COMPARE, miss:
  - Victim = lowest-index invalid way, else the PLRU victim.
  - Victim valid && dirty: go to WRITEBACK. Otherwise go to ALLOCATE.
- WRITEBACK:
  - dfp_write=1, dfp_addr={victim tag, index, 5'b0}, dfp_wdata = victim line.
  - Held stable until dfp_resp. On dfp_resp clear dirty and go to ALLOCATE.
- ALLOCATE:
  - dfp_read=1, dfp_addr={req tag, index, 5'b0}, held until dfp_resp.
  - On dfp_resp: write dfp_rdata into the victim way; set valid=1, dirty=0, tag=req tag; go to COMPARE.
  - The replayed compare then hits.
- PLRU: WAYS-1 bits per set as a binary tree. Node bit 0 = victim lies in the lower half.
  - On an access to way w, every node on w's path points away from w.
  - Only COMPARE hits update PLRU. A fill is always followed by a hit that updates it.
- dfp_resp outside WRITEBACK/ALLOCATE is ignored. dfp_read and dfp_write are never both 1.
- Reset (asynchronous assertion), mid-operation included:
  - all valid, dirty and PLRU bits cleared; state=IDLE.
  - all outputs 0, including dfp_read/dfp_write, which deassert immediately.
  - Any in-flight dfp transaction is abandoned.

## Timing
- Hit latency: request sampled in IDLE at edge N; ufp_resp high during cycle N+1. Next request can be sampled at edge N+2.
- Clean miss: ufp_resp 2 cycles after the ALLOCATE dfp_resp edge (COMPARE replay).
- Dirty miss: adds the full WRITEBACK handshake before ALLOCATE.
- dfp_addr, dfp_wdata, dfp_read and dfp_write are registered/state-decoded. They are stable for the entire request, including a zero-wait dfp_resp in the first request cycle.
- ufp_resp is never asserted in two consecutive cycles.

## Structure
- Package cache_types holds:
  - the typedef enum for the state
  - the line/offset width constants (LINE_BITS=256, OFF_W=5)
  - a helper function for log2 of the parameters
- Sub-module plru_tree (parameter WAYS) is combinational:
  - inputs: the current bits and the accessed way
  - outputs: the next bits and the victim way
- Tag, valid, dirty, data and PLRU storage are flop arrays inside cache_nway, indexed by set.

## Test plan
- After reset, read 0x0000_0040 rmask=F:
  - dfp_read with dfp_addr=0x40; return a line with word0=0xDEADBEEF → ufp_rdata=0xDEADBEEF.
  - Repeat the read → ufp_resp 1 cycle after sampling, with no dfp_read.
- Line at 0x40 has word1=0x11223344:
  - write 0x44 wmask=0011 wdata=0x0000ABCD → ufp_resp.
  - Read 0x44 → 0x1122ABCD.
- WAYS=4, SETS=16:
  - touch 0x040 (write), 0x240, 0x440, 0x640 in order; then read 0x840.
  - → dfp_write at 0x040 carrying the merged line, then dfp_read at 0x840.
  - Re-read 0x240 → hit.
- dfp_resp delays of 0, 1 and 10 cycles on both fill and writeback → dfp_addr/dfp_read/dfp_write stable throughout; identical ufp results.
- rst_n low during WRITEBACK → dfp_write=0 and ufp_resp=0 within the same cycle. After release, read 0x040 → miss (dfp_read at 0x040).
- Parameter sweep WAYS=2/SETS=64 and WAYS=8/SETS=4:
  - random traffic against a flat reference memory model → every ufp_rdata matches.
  - No dfp_write of a clean line.
